// File: rtl/agc_pkg.sv
// Shared types and defaults for the auto clock-gate controller.
package agc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        GATED = 2'd2
    } agc_state_t;

    localparam int unsigned AGC_IDLE_CYC_DEF = 4;
    localparam int unsigned AGC_CNT_W_DEF    = 8;
    localparam int unsigned AGC_IDLE_W       = 8;

endpackage

// File: rtl/icg_cell.sv
// Glitch-free integrated clock gate: low-transparent enable latch ANDed with CLK.
module icg_cell (
    input  logic CLK,
    input  logic EN,
    output logic GCLK
);

    logic en_lat;

    // NOTE: this latch is intentional; it holds EN stable for the whole high phase so GCLK cannot glitch.
    always_latch begin
        if (!CLK) begin
            en_lat <= EN;
        end
    end

    assign GCLK = CLK & en_lat;

endmodule

// File: rtl/auto_gate_ctrl.sv
// Automatic clock-gate controller: gates GCLK after IDLE_CYC idle cycles of EN_REQ.
// Define AGC_STATS_EN to build the saturating GATE_CNT suppressed-cycle counter.
module auto_gate_ctrl
    import agc_pkg::agc_state_t;
    import agc_pkg::AGC_IDLE_CYC_DEF;
    import agc_pkg::AGC_CNT_W_DEF;
    import agc_pkg::AGC_IDLE_W;
#(
    parameter int unsigned IDLE_CYC = AGC_IDLE_CYC_DEF,
    parameter int unsigned CNT_W    = AGC_CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN_REQ,
    input  logic             TEST_EN,
    output logic             GCLK,
    output logic             GCLK_EN,
    output logic             GATED,
    output logic [CNT_W-1:0] GATE_CNT
);

    localparam logic [AGC_IDLE_W-1:0] IDLE_LAST = AGC_IDLE_W'(IDLE_CYC - 1);

    agc_state_t            state_q, state_d;
    logic [AGC_IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  gated_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= agc_pkg::RUN;
            idle_cnt_q <= '0;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            gated_q    <= (state_d == agc_pkg::GATED);
        end
    end

    // NOTE: defaults at the top of the comb block keep every path assigned, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            agc_pkg::RUN: begin
                if (!EN_REQ) begin
                    if (IDLE_CYC == 1) begin
                        state_d = agc_pkg::GATED;
                    end else begin
                        state_d    = agc_pkg::COUNT;
                        idle_cnt_d = AGC_IDLE_W'(1);
                    end
                end
            end
            agc_pkg::COUNT: begin
                if (EN_REQ) begin
                    state_d    = agc_pkg::RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = agc_pkg::GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + AGC_IDLE_W'(1);
                end
            end
            agc_pkg::GATED: begin
                if (EN_REQ) begin
                    state_d = agc_pkg::RUN;
                end
            end
            default: begin
                state_d    = agc_pkg::RUN;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Wake-up is combinational on EN_REQ, giving zero-cycle latency back to a running clock.
    always_comb begin
        GCLK_EN = EN_REQ | TEST_EN | (state_q != agc_pkg::GATED);
    end

    assign GATED = gated_q;

    icg_cell u_icg (
        .CLK  (CLK),
        .EN   (GCLK_EN),
        .GCLK (GCLK)
    );

`ifdef AGC_STATS_EN
    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;

    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if ((state_q == agc_pkg::GATED) && !GCLK_EN && (gate_cnt_q != '1)) begin
            gate_cnt_d = gate_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gate_cnt_q <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
        end
    end

    assign GATE_CNT = gate_cnt_q;
`else
    assign GATE_CNT = '0;
`endif

endmodule

// File: tb/tb_auto_gate_ctrl.sv
// Randomised bench for auto_gate_ctrl, two configurations checked against an idle-run-length model.
module tb_auto_gate_ctrl;

    localparam int IDLE_A = 4;
    localparam int CNTW_A = 8;
    localparam int IDLE_B = 1;
    localparam int CNTW_B = 4;
    localparam int MAX_A  = (1 << CNTW_A) - 1;
    localparam int MAX_B  = (1 << CNTW_B) - 1;

`ifdef AGC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N, EN_REQ, TEST_EN;

    logic              gclk_a, gclk_en_a, gated_a;
    logic [CNTW_A-1:0] cnt_a;
    logic              gclk_b, gclk_en_b, gated_b;
    logic [CNTW_B-1:0] cnt_b;

    auto_gate_ctrl #(.IDLE_CYC(IDLE_A), .CNT_W(CNTW_A)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .EN_REQ(EN_REQ), .TEST_EN(TEST_EN),
        .GCLK(gclk_a), .GCLK_EN(gclk_en_a), .GATED(gated_a), .GATE_CNT(cnt_a)
    );

    auto_gate_ctrl #(.IDLE_CYC(IDLE_B), .CNT_W(CNTW_B)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .EN_REQ(EN_REQ), .TEST_EN(TEST_EN),
        .GCLK(gclk_b), .GCLK_EN(gclk_en_b), .GATED(gated_b), .GATE_CNT(cnt_b)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: gating is purely "EN_REQ has been sampled low on at least IDLE_CYC consecutive edges".
    int low_a, low_b, mcnt_a, mcnt_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        low_a = 0; low_b = 0; mcnt_a = 0; mcnt_b = 0;
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            model_reset();
        end else begin
            if (STATS && low_a >= IDLE_A && !EN_REQ && !TEST_EN && mcnt_a < MAX_A) mcnt_a++;
            if (STATS && low_b >= IDLE_B && !EN_REQ && !TEST_EN && mcnt_b < MAX_B) mcnt_b++;
            low_a = EN_REQ ? 0 : ((low_a < 1000) ? low_a + 1 : low_a);
            low_b = EN_REQ ? 0 : ((low_b < 1000) ? low_b + 1 : low_b);
        end
    endtask

    task automatic check_static(input string tag);
        check({tag, ":gated_a"},   32'(gated_a),   32'(low_a >= IDLE_A));
        check({tag, ":gclk_en_a"}, 32'(gclk_en_a), 32'(EN_REQ | TEST_EN | !(low_a >= IDLE_A)));
        check({tag, ":cnt_a"},     32'(cnt_a),     32'(mcnt_a));
        check({tag, ":gated_b"},   32'(gated_b),   32'(low_b >= IDLE_B));
        check({tag, ":gclk_en_b"}, 32'(gclk_en_b), 32'(EN_REQ | TEST_EN | !(low_b >= IDLE_B)));
        check({tag, ":cnt_b"},     32'(cnt_b),     32'(mcnt_b));
    endtask

    // One clock: drive in the low phase, check statics, then check the gated pulse after the edge.
    task automatic cycle(input bit en, input bit te, input string tag);
        bit exp_a, exp_b;
        @(negedge CLK);
        EN_REQ  = en;
        TEST_EN = te;
        #1;
        check_static(tag);
        check({tag, ":gclk_a_low"}, 32'(gclk_a), 32'(0));
        check({tag, ":gclk_b_low"}, 32'(gclk_b), 32'(0));
        exp_a = en | te | !(low_a >= IDLE_A);
        exp_b = en | te | !(low_b >= IDLE_B);
        @(posedge CLK);
        model_edge();
        #1;
        check({tag, ":gclk_a_high"}, 32'(gclk_a), 32'(exp_a));
        check({tag, ":gclk_b_high"}, 32'(gclk_b), 32'(exp_b));
    endtask

    // Called right after cycle(): asynchronous assert in the high phase, immediate check.
    task automatic reset_pulse(input int hold);
        #1;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_static("rst_now");
        check("rst_gclk_en_a", 32'(gclk_en_a), 32'(1));
        check("rst_cnt_b",     32'(cnt_b),     32'(0));
        for (int i = 0; i < hold; i++) cycle(1'b0, 1'b0, "rst_hold");
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        int run_len;
        bit run_val;

        RST_N   = 1'b0;
        EN_REQ  = 1'b0;
        TEST_EN = 1'b0;
        model_reset();
        #1;
        check_static("reset");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "reset_hold");
        #1;
        RST_N = 1'b1;

        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, "run");
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, "idle_gate");
        check("sat_b_15", 32'(cnt_b), STATS ? 32'(15) : 32'(0));
        check("cnt_a_20", 32'(cnt_a), STATS ? 32'(20) : 32'(0));

        cycle(1'b1, 1'b0, "wake");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "after_wake");

        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "regate");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, "test_en");
        check("test_en_gated_a", 32'(gated_a), 32'(1));
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, "test_off");

        reset_pulse(2);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, "post_rst");

        for (int r = 0; r < 6; r++) begin
            cycle(1'b0, 1'b0, "pat0");
            cycle(1'b0, 1'b0, "pat0");
            cycle(1'b0, 1'b0, "pat0");
            cycle(1'b1, 1'b0, "pat1");
        end
        check("pattern_never_gated", 32'(gated_a), 32'(0));

        for (int i = 0; i < 60; i++) begin
            run_len = $urandom_range(1, 9);
            run_val = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < run_len; k++) begin
                cycle(run_val, ($urandom_range(0, 11) == 0), "rand");
            end
            if ($urandom_range(0, 24) == 0) reset_pulse($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
